conv2_window_buf: RTL and testbench
===================================

# conv2_window_buf

Window generator between the pool-1 stage and the conv-2 multiply-accumulate array. It accepts the 3-channel, 12x12, ReLU'd pooled stream in raster order, one pixel per `valid_in`. For every position where a full KxK neighbourhood exists, it presents that KxK window for all three channels. Output is 8x8 = 64 windows per frame, each flagged by a one-cycle `valid_out`.

## Interface
- `DATA_BIT`, 12: pixel width; unsigned, since the inputs are post-ReLU.
- `WIDTH`, 12: pooled frame width.
- `HEIGHT`, 12: pooled frame height.
- `K`, 5: kernel size of conv-2.
- `COL_BIT`, 4: width of the column and row counters.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: pixel strobe; gaps between strobes allowed.
- `data_in_1`, `data_in_2`, `data_in_3` in DATA_BIT: channel pixels.
- `window_1`, `window_2`, `window_3` out K*K*DATA_BIT: flattened windows; element (r,c) at bits [(r*K+c)*DATA_BIT +: DATA_BIT].
- `valid_out` out 1: window valid, one-cycle pulse.
- `frame_done` out 1: present only with the macro in Configuration.

## Operation
- Per channel: shift register of depth L = (K-1)*WIDTH + K; shifts only on `valid_in`, with the new pixel entering at the tail.
- Tap mapping:
  - Element (r,c) = register at offset (K-1-r)*WIDTH + (K-1-c) from the newest entry.
  - r=0 is the oldest row; c=0 is the leftmost column.
  - (K-1,K-1) is the pixel just accepted.
- Window outputs are combinational taps of the shift registers; no second register copy.
- Counters:
  - `col` and `row` track the accepted pixel. `col` advances on every `valid_in`.
  - At `col` = WIDTH-1: `col` goes to 0 and `row` increments.
  - At (`row` = HEIGHT-1, `col` = WIDTH-1): both wrap to 0, ready for the next frame.
- `valid_out` is registered: next edge value = `valid_in` && `row` >= K-1 && `col` >= K-1, evaluated on the accepted pixel's coordinates.
- Stale data from the previous frame in the shift register is never exposed. Positions with `row` < K-1 or `col` < K-1 never assert `valid_out`, so no clear is needed between frames.
- Without `valid_in`: no shift, no counter change, `valid_out` goes to 0.
- Reset, asynchronous at any time including mid-frame:
  - Counters, `valid_out`, `frame_done` and all shift-register stages go to 0, so `window_*` = 0.
  - The next accepted pixel is treated as (0,0).

## Timing
- Latency: 1 cycle. The pixel accepted at edge N produces `valid_out` = 1 during cycle N+1, with `window_*` stable throughout that cycle.
- Back-to-back `valid_in` in the valid region gives consecutive `valid_out` pulses, each showing the window shifted by one column.
- No backpressure: the consumer must take each window in its `valid_out` cycle.
- Row wrap: the first valid window of row r ≥ K-1 is at `col` = K-1. Columns 0..K-2 produce no pulse.

## Configuration
- `CONV2_WIN_FRAME_DONE_EN`
  - Defined: adds output `frame_done`, registered and reset to 0. It pulses for 1 cycle together with the `valid_out` of the last window of a frame, i.e. the pixel at (HEIGHT-1, WIDTH-1).
  - Undefined: the port and its logic are absent; everything else is identical.

## Structure
- Shared package `cnn_pkg`: `DATA_BIT`, `POOL1_WIDTH`/`POOL1_HEIGHT` (12), `CONV2_K` (5), and a `pixel_t` typedef for an unsigned DATA_BIT pixel.
- Sub-module `win_shift_chan`: one channel's L-deep shift register plus tap flattening. It is instantiated 3x and shares enable and reset.
- The top level holds the counters, `valid_out` and `frame_done`.

## Test plan
- Ramp: ch1 pixel = row*12+col, ch2 = ch1+200, ch3 = 4095-ch1, no gaps.
  - First `valid_out` one cycle after the 53rd pixel, (4,4).
  - `window_1` (0,0) = 0 and (4,4) = 52; `window_2` (0,0) = 200; `window_3` (4,4) = 4043.
- Full frame: exactly 64 `valid_out` pulses.
  - Pulse k shows (0,0) = (k/8)*12 + k%8.
  - No pulses for `col` < 4 or `row` < 4.
- Gapped input: random 0-3 idle cycles between pixels.
  - Same 64 windows as the ramp test; `valid_out` low during idle cycles; window outputs unchanged during gaps.
- Back-to-back frames: two ramps with the second offset by +1000.
  - 128 pulses total; the first window of frame 2 has (0,0) = 1000 and contains no frame-1 values.
- Reset mid-frame: assert `rst` after pixel (6,3).
  - `valid_out`/`window_*` = 0 immediately; a restarted ramp reproduces the first-window values of the ramp test.
- Macro on: `frame_done` = 1 only in the 64th `valid_out` cycle of each frame. Macro off: the build has no `frame_done` port.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN datapath stages.
//   DATA_BIT      : pixel width (unsigned, post-ReLU)
//   POOL1_WIDTH   : pooled frame width produced by pool-1
//   POOL1_HEIGHT  : pooled frame height produced by pool-1
//   CONV2_K       : conv-2 kernel size
//   CONV2_COL_BIT : width of the conv-2 window row/column counters
//   pixel_t       : one unsigned pixel
//   win_tap_offset: distance from the newest shift-register entry to window
//                   element (r,c)
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int unsigned DATA_BIT      = 12;
  localparam int unsigned POOL1_WIDTH   = 12;
  localparam int unsigned POOL1_HEIGHT  = 12;
  localparam int unsigned CONV2_K       = 5;
  localparam int unsigned CONV2_COL_BIT = 4;

  typedef logic [DATA_BIT-1:0] pixel_t;

  // Row r=0 is the oldest row and c=0 the leftmost column, so element
  // (k-1,k-1) is the pixel just shifted in (offset 0).
  function automatic int unsigned win_tap_offset(input int unsigned r,
                                                 input int unsigned c,
                                                 input int unsigned k,
                                                 input int unsigned width);
    return (k - 1 - r) * width + (k - 1 - c);
  endfunction

endpackage : cnn_pkg

// File: rtl/win_shift_chan.sv
// -----------------------------------------------------------------------------
// win_shift_chan
// One channel of the conv-2 window generator: an L = (K-1)*WIDTH + K deep
// pixel shift register with the KxK window taps flattened onto one bus.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset, clears every stage
//   shift_en_i : shift strobe; the new pixel enters at stage 0 (newest)
//   pix_i      : incoming pixel
//   window_o   : flattened window, element (r,c) at [(r*K+c)*DATA_BIT +: DATA_BIT]
// -----------------------------------------------------------------------------
module win_shift_chan #(
  parameter int unsigned DATA_BIT = cnn_pkg::DATA_BIT,
  parameter int unsigned WIDTH    = cnn_pkg::POOL1_WIDTH,
  parameter int unsigned K        = cnn_pkg::CONV2_K
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en_i,
  input  logic [DATA_BIT-1:0]       pix_i,
  output logic [K*K*DATA_BIT-1:0]   window_o
);

  import cnn_pkg::*;

  localparam int unsigned L = (K - 1) * WIDTH + K;

  // Stage 0 holds the newest pixel, stage L-1 the oldest one still needed.
  logic [DATA_BIT-1:0] sr_q [L];

  // Shift register; holds when no pixel is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(L); i++) begin
        sr_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      sr_q[0] <= pix_i;
      for (int i = 1; i < int'(L); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  // Window taps are pure wiring from the shift-register stages.
  for (genvar r = 0; r < int'(K); r++) begin : g_row
    for (genvar c = 0; c < int'(K); c++) begin : g_col
      localparam int unsigned TAP = win_tap_offset(r, c, K, WIDTH);
      assign window_o[(r*K+c)*DATA_BIT +: DATA_BIT] = sr_q[TAP];
    end
  end

endmodule : win_shift_chan

// File: rtl/conv2_window_buf.sv
// -----------------------------------------------------------------------------
// conv2_window_buf
// Window generator between pool-1 and the conv-2 MAC array. Accepts the
// 3-channel pooled stream in raster order and presents the KxK window of all
// three channels for every position where a full neighbourhood exists
// (8x8 = 64 windows per 12x12 frame).
// Optional build macro: CONV2_WIN_FRAME_DONE_EN adds the frame_done output.
// Ports:
//   clk                    : clock
//   rst                    : asynchronous active-high reset
//   valid_in               : pixel strobe, gaps allowed
//   data_in_1..3           : channel pixels
//   window_1..3            : flattened KxK windows (combinational taps)
//   valid_out              : one-cycle window valid, registered
//   frame_done             : (macro only) pulses with the last window of a frame
// -----------------------------------------------------------------------------
module conv2_window_buf #(
  parameter int unsigned DATA_BIT = cnn_pkg::DATA_BIT,
  parameter int unsigned WIDTH    = cnn_pkg::POOL1_WIDTH,
  parameter int unsigned HEIGHT   = cnn_pkg::POOL1_HEIGHT,
  parameter int unsigned K        = cnn_pkg::CONV2_K,
  parameter int unsigned COL_BIT  = cnn_pkg::CONV2_COL_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DATA_BIT-1:0]       data_in_1,
  input  logic [DATA_BIT-1:0]       data_in_2,
  input  logic [DATA_BIT-1:0]       data_in_3,
  output logic [K*K*DATA_BIT-1:0]   window_1,
  output logic [K*K*DATA_BIT-1:0]   window_2,
  output logic [K*K*DATA_BIT-1:0]   window_3,
  output logic                      valid_out
`ifdef CONV2_WIN_FRAME_DONE_EN
  ,
  output logic                      frame_done
`endif
);

  import cnn_pkg::*;

  localparam logic [COL_BIT-1:0] COL_LAST = COL_BIT'(WIDTH - 1);
  localparam logic [COL_BIT-1:0] ROW_LAST = COL_BIT'(HEIGHT - 1);
  localparam logic [COL_BIT-1:0] WIN_MIN  = COL_BIT'(K - 1);

  logic [COL_BIT-1:0] col_q, col_d;
  logic [COL_BIT-1:0] row_q, row_d;
  logic               valid_q, valid_d;
  logic               at_col_last;
  logic               at_row_last;
  logic               in_window_region;

  // Three identical channel buffers sharing the accept strobe and reset.
  win_shift_chan #(
    .DATA_BIT (DATA_BIT),
    .WIDTH    (WIDTH),
    .K        (K)
  ) u_chan_1 (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (valid_in),
    .pix_i      (data_in_1),
    .window_o   (window_1)
  );

  win_shift_chan #(
    .DATA_BIT (DATA_BIT),
    .WIDTH    (WIDTH),
    .K        (K)
  ) u_chan_2 (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (valid_in),
    .pix_i      (data_in_2),
    .window_o   (window_2)
  );

  win_shift_chan #(
    .DATA_BIT (DATA_BIT),
    .WIDTH    (WIDTH),
    .K        (K)
  ) u_chan_3 (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (valid_in),
    .pix_i      (data_in_3),
    .window_o   (window_3)
  );

  // Position decode of the pixel being accepted this cycle.
  assign at_col_last      = (col_q == COL_LAST);
  assign at_row_last      = (row_q == ROW_LAST);
  // Positions left of / above K-1 would expose pixels from the previous row
  // or frame, so they never pulse; this is why no clear is needed per frame.
  assign in_window_region = (row_q >= WIN_MIN) && (col_q >= WIN_MIN);

  // Raster counters and window-valid next state.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    if (valid_in) begin
      valid_d = in_window_region;
      if (at_col_last) begin
        col_d = '0;
        row_d = at_row_last ? '0 : row_q + COL_BIT'(1);
      end else begin
        col_d = col_q + COL_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out = valid_q;

`ifdef CONV2_WIN_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  // Last pixel of the frame is always inside the window region, so this
  // coincides with the final valid_out pulse.
  always_comb begin
    frame_done_d = valid_in && at_col_last && at_row_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

endmodule : conv2_window_buf

// File: tb/tb_conv2_window_buf.sv
module tb_conv2_window_buf;

  localparam int DW = 12;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int KK = 5;
  localparam int WB = KK * KK * DW;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in_1, data_in_2, data_in_3;
  logic [WB-1:0] window_1, window_2, window_3;
  logic          valid_out;
`ifdef CONV2_WIN_FRAME_DONE_EN
  logic          frame_done;
`endif

  conv2_window_buf dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_in_3 (data_in_3),
    .window_1  (window_1),
    .window_2  (window_2),
    .window_3  (window_3),
    .valid_out (valid_out)
`ifdef CONV2_WIN_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] w1;
    logic [WB-1:0] w2;
    logic [WB-1:0] w3;
    bit            last;
  } exp_t;

  exp_t q[$];

  int checks;
  int errors;
  int exp_pulses;
  bit done;
  bit exp_flag;

  // Reference model: the current frame as a picture plus the raster position.
  int img1 [H][W];
  int img2 [H][W];
  int img3 [H][W];
  int mr, mc;

  task automatic send(input int d1, input int d2, input int d3, input int gap);
    exp_t e;
    repeat (gap) begin
      valid_in = 1'b0;
      exp_flag = 1'b0;
      @(posedge clk); #1;
    end
    img1[mr][mc] = d1;
    img2[mr][mc] = d2;
    img3[mr][mc] = d3;
    data_in_1 = DW'(d1);
    data_in_2 = DW'(d2);
    data_in_3 = DW'(d3);
    valid_in  = 1'b1;
    exp_flag  = (mr >= KK - 1) && (mc >= KK - 1);
    if (exp_flag) begin
      for (int r = 0; r < KK; r++) begin
        for (int c = 0; c < KK; c++) begin
          e.w1[(r*KK+c)*DW +: DW] = DW'(img1[mr-KK+1+r][mc-KK+1+c]);
          e.w2[(r*KK+c)*DW +: DW] = DW'(img2[mr-KK+1+r][mc-KK+1+c]);
          e.w3[(r*KK+c)*DW +: DW] = DW'(img3[mr-KK+1+r][mc-KK+1+c]);
        end
      end
      e.last = (mr == H - 1) && (mc == W - 1);
      q.push_back(e);
      exp_pulses++;
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    exp_flag = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ramp_frame(input int off, input int maxgap, input int npix);
    int v;
    for (int p = 0; p < npix; p++) begin
      v = (p / W) * W + (p % W) + off;
      send(v, v + 200, 4095 - v, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic rand_frame(input int maxgap);
    for (int p = 0; p < W * H; p++) begin
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, maxgap)));
    end
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; valid_in = 1'b0; exp_flag = 1'b0; done = 1'b0;
    data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
    mr = 0; mc = 0; exp_pulses = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    ramp_frame(0, 0, W * H);
    ramp_frame(0, 3, W * H);
    idle(3);
    ramp_frame(0, 0, W * H);
    ramp_frame(1000, 0, W * H);
    rand_frame(2);
    idle(2);
    // Stop right after pixel (6,3) and reset asynchronously mid-cycle.
    ramp_frame(0, 0, 6 * W + 4);
    valid_in = 1'b0;
    exp_flag = 1'b0;
    #1 rst = 1'b1;
    mr = 0; mc = 0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);
    ramp_frame(0, 1, W * H);
    idle(5);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    bit prev_exp, prev_vin, prev_rst, fd_exp;
    logic [WB-1:0] s1, s2, s3;
    int obs_pulses, k;
    exp_t e;
    checks = 0; errors = 0; obs_pulses = 0;
    prev_exp = 1'b0; prev_vin = 1'b0; prev_rst = 1'b1;
    s1 = '0; s2 = '0; s3 = '0;
    while (!done) begin
      @(negedge clk);
      fd_exp = 1'b0;
      if (rst) begin
        checks++;
        if (valid_out !== 1'b0 || window_1 !== '0 || window_2 !== '0 || window_3 !== '0) begin
          errors++;
          $display("FAIL reset_zero: valid_out=%b w1_00=%0d w2_00=%0d w3_44=%0d required all 0",
                   valid_out, window_1[DW-1:0], window_2[DW-1:0], window_3[WB-1 -: DW]);
        end
        q.delete();
      end else begin
        checks++;
        if (valid_out !== prev_exp) begin
          errors++;
          $display("FAIL valid_out_timing: got %b required %b at %0t", valid_out, prev_exp, $time);
        end
        if (valid_out === 1'b1) begin
          k = obs_pulses;
          obs_pulses++;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: got valid_out=1 required no pending window at %0t", $time);
          end else begin
            e = q.pop_front();
            fd_exp = e.last;
            checks++;
            if (window_1 !== e.w1) begin
              errors++;
              $display("FAIL window_1 pulse %0d: got %h required %h", k, window_1, e.w1);
            end
            checks++;
            if (window_2 !== e.w2) begin
              errors++;
              $display("FAIL window_2 pulse %0d: got %h required %h", k, window_2, e.w2);
            end
            checks++;
            if (window_3 !== e.w3) begin
              errors++;
              $display("FAIL window_3 pulse %0d: got %h required %h", k, window_3, e.w3);
            end
          end
          // First frame is a gap-free ramp: pulse k has (0,0) = (k/8)*12 + k%8.
          if (k < 64) begin
            checks++;
            if (int'(window_1[DW-1:0]) != (k / 8) * 12 + k % 8) begin
              errors++;
              $display("FAIL ramp_origin pulse %0d: got %0d required %0d",
                       k, window_1[DW-1:0], (k / 8) * 12 + k % 8);
            end
          end
          if (k == 0) begin
            checks++;
            if (window_1[DW-1:0] !== 12'd0 || window_1[WB-1 -: DW] !== 12'd52 ||
                window_2[DW-1:0] !== 12'd200 || window_3[WB-1 -: DW] !== 12'd4043) begin
              errors++;
              $display("FAIL first_window: got w1_00=%0d w1_44=%0d w2_00=%0d w3_44=%0d required 0 52 200 4043",
                       window_1[DW-1:0], window_1[WB-1 -: DW], window_2[DW-1:0], window_3[WB-1 -: DW]);
            end
          end
        end
`ifdef CONV2_WIN_FRAME_DONE_EN
        checks++;
        if (frame_done !== fd_exp) begin
          errors++;
          $display("FAIL frame_done: got %b required %b at %0t", frame_done, fd_exp, $time);
        end
`endif
        if (!prev_vin && !prev_rst) begin
          checks++;
          if (window_1 !== s1 || window_2 !== s2 || window_3 !== s3) begin
            errors++;
            $display("FAIL gap_hold: window changed without valid_in at %0t (w1_44 got %0d required %0d)",
                     $time, window_1[WB-1 -: DW], s1[WB-1 -: DW]);
          end
        end
      end
      s1 = window_1; s2 = window_2; s3 = window_3;
      prev_exp = valid_in && exp_flag;
      prev_vin = valid_in;
      prev_rst = rst;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_windows: got %0d unconsumed required 0", q.size());
    end
    checks++;
    if (obs_pulses != exp_pulses) begin
      errors++;
      $display("FAIL pulse_count_model: got %0d required %0d", obs_pulses, exp_pulses);
    end
    // 6 full frames plus 16 windows from rows 4..5 before the mid-frame reset.
    checks++;
    if (obs_pulses != 6 * 64 + 16) begin
      errors++;
      $display("FAIL pulse_count_total: got %0d required %0d", obs_pulses, 6 * 64 + 16);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule : tb_conv2_window_buf
